ls_buffer: RTL

In-order load/store buffer that receives ready memory operations from the load/store reservation station and executes them one at a time through the memory controller. Completed operations are broadcast on its own CDB port. Stores are held until they reach the head of the ROB. The block also generates the full indication that the reservation station samples before handing an operation over.

---
 rtl/ls_buffer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ls_buffer.sv
// In-order load/store buffer: a circular FIFO of ready memory operations issued
// one at a time to the memory controller, with results broadcast on its own CDB port.
module ls_buffer #(
    parameter int DEPTH = 8,
    parameter int ROBW  = 4,
    parameter int OPW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [OPW-1:0]  opcode_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     r2data_i,
    input  logic [ROBW-1:0] id_i,
    output logic            full_o,
    input  logic [ROBW-1:0] rob_head_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic [1:0]      mem_size_o,
    input  logic            mem_done_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            cdb_en_o,
    output logic [ROBW-1:0] cdb_id_o,
    output logic [31:0]     cdb_data_o
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [OPW-1:0] OP_LB  = OPW'(0);
    localparam logic [OPW-1:0] OP_LH  = OPW'(1);
    localparam logic [OPW-1:0] OP_LW  = OPW'(2);
    localparam logic [OPW-1:0] OP_LBU = OPW'(3);
    localparam logic [OPW-1:0] OP_LHU = OPW'(4);
    localparam logic [OPW-1:0] OP_SB  = OPW'(5);
    localparam logic [OPW-1:0] OP_SH  = OPW'(6);
    localparam logic [OPW-1:0] OP_SW  = OPW'(7);

    logic [OPW-1:0]  op_mem   [DEPTH];
    logic [31:0]     addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [ROBW-1:0] id_mem   [DEPTH];

    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [PW:0]     count_reg;
    logic [PW:0]     count_next;
    logic [0:0]      state_reg;

    logic            full_reg;
    logic            mem_req_reg;
    logic            mem_we_reg;
    logic [31:0]     mem_addr_reg;
    logic [31:0]     mem_wdata_reg;
    logic [1:0]      mem_size_reg;
    logic            cdb_en_reg;
    logic [ROBW-1:0] cdb_id_reg;
    logic [31:0]     cdb_data_reg;

    logic            push;
    logic            pop;
    logic [OPW-1:0]  head_op;
    logic            head_is_store;
    logic            head_can_issue;
    logic [1:0]      head_size;
    logic [31:0]     load_data;

    // An overflowing push (count already DEPTH) is dropped.
    assign push = rdy && !rst && !clr_i && en_i && (count_reg != (PW+1)'(DEPTH));
    assign pop  = rdy && (state_reg == S_WAIT) && mem_done_i;

    assign head_op        = op_mem[head_reg];
    assign head_is_store  = (head_op == OP_SB) || (head_op == OP_SH) || (head_op == OP_SW);
    // Stores wait for the ROB head so they never execute speculatively.
    assign head_can_issue = (count_reg != '0) && (!head_is_store || (id_mem[head_reg] == rob_head_i));

    always_comb begin
        head_size = 2'd2;
        case (head_op)
            OP_LB, OP_LBU, OP_SB: head_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: head_size = 2'd1;
            default:              head_size = 2'd2;
        endcase
    end

    always_comb begin
        load_data = mem_rdata_i;
        case (head_op)
            OP_LB:   load_data = {{24{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
            OP_LH:   load_data = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
            OP_LBU:  load_data = {24'd0, mem_rdata_i[7:0]};
            OP_LHU:  load_data = {16'd0, mem_rdata_i[15:0]};
            OP_LW:   load_data = mem_rdata_i;
            default: load_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + (PW+1)'(1);
        end else if (pop && !push) begin
            count_next = count_reg - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[tail_reg]   <= opcode_i;
            addr_mem[tail_reg] <= addr_i;
            data_mem[tail_reg] <= r2data_i;
            id_mem[tail_reg]   <= id_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            state_reg     <= S_IDLE;
            full_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_size_reg  <= '0;
            cdb_en_reg    <= 1'b0;
            cdb_id_reg    <= '0;
            cdb_data_reg  <= '0;
        end else if (rdy) begin
            cdb_en_reg <= 1'b0;
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            case (state_reg)
                S_IDLE: begin
                    if (head_can_issue) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= head_is_store;
                        mem_addr_reg  <= addr_mem[head_reg];
                        mem_wdata_reg <= data_mem[head_reg];
                        mem_size_reg  <= head_size;
                        state_reg     <= S_WAIT;
                    end
                end
                default: begin
                    if (mem_done_i) begin
                        mem_req_reg  <= 1'b0;
                        head_reg     <= head_reg + PW'(1);
                        cdb_en_reg   <= 1'b1;
                        cdb_id_reg   <= id_mem[head_reg];
                        cdb_data_reg <= head_is_store ? 32'd0 : load_data;
                        state_reg    <= S_IDLE;
                    end
                end
            endcase
            count_reg <= count_next;
            // Two slots of slack cover the station's one-cycle reaction to full.
            full_reg  <= (count_next >= (PW+1)'(DEPTH - 2));
        end
    end

    assign full_o      = full_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign mem_size_o  = mem_size_reg;
    assign cdb_en_o    = cdb_en_reg;
    assign cdb_id_o    = cdb_id_reg;
    assign cdb_data_o  = cdb_data_reg;
endmodule
